// File: rtl/mrv1_pkg.sv
// Shared types for the mrv1 warp pipeline: functional-unit encoding and FU count.
package mrv1_pkg;

  typedef enum logic [1:0] {
    MRV_FU_ALU = 2'd0,
    MRV_FU_MUL = 2'd1,
    MRV_FU_LSU = 2'd2,
    MRV_FU_BRU = 2'd3
  } mrv_fu_type_e;

  localparam int MRV_FU_NUM = 4;

endpackage

// File: rtl/mrv_rr_arbiter.sv
// N-way round-robin picker: grants the first requester at or after ptr, wrapping modulo N.
module mrv_rr_arbiter #(
  parameter int N = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx
);

  int w_idx;

  // Scan from the far end back toward ptr so the last hit is the nearest requester.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    w_idx   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = (int'(ptr) + i) % N;
      if (req[w_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(w_idx);
      end else begin
        gnt_vld = gnt_vld;
      end
    end
  end

endmodule

// File: rtl/mrv_warp_issue_sched.sv
// Per-warp issue scheduler: one held instruction slot per warp, a per-warp register
// scoreboard, and a round-robin pick among hazard-free warps whose FU is ready.
module mrv_warp_issue_sched
  import mrv1_pkg::*;
#(
  parameter int NUM_TW_P        = 8,
  parameter int rf_addr_width_p = 5,
  localparam int twid_width_lp  = $clog2(NUM_TW_P)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       dec_vld_i,
  output logic                       dec_rdy_o,
  input  logic [twid_width_lp-1:0]   dec_twid_i,
  input  mrv_fu_type_e               dec_fu_type_i,
  input  logic                       dec_rs0_vld_i,
  input  logic                       dec_rs1_vld_i,
  input  logic                       dec_rd_vld_i,
  input  logic [rf_addr_width_p-1:0] dec_rs0_addr_i,
  input  logic [rf_addr_width_p-1:0] dec_rs1_addr_i,
  input  logic [rf_addr_width_p-1:0] dec_rd_addr_i,
  input  logic [MRV_FU_NUM-1:0]      fu_rdy_i,
  output logic                       issue_vld_o,
  output logic [twid_width_lp-1:0]   issue_twid_o,
  output mrv_fu_type_e               issue_fu_type_o,
  input  logic                       wb_vld_i,
  input  logic [twid_width_lp-1:0]   wb_twid_i,
  input  logic [rf_addr_width_p-1:0] wb_rd_addr_i,
  input  logic                       flush_vld_i,
  input  logic [twid_width_lp-1:0]   flush_twid_i
);

  localparam int NUM_REGS_LP = 2 ** rf_addr_width_p;

  logic [NUM_TW_P-1:0]        r_slot_vld;
  mrv_fu_type_e               r_fu      [NUM_TW_P];
  logic [NUM_TW_P-1:0]        r_rs0_vld;
  logic [NUM_TW_P-1:0]        r_rs1_vld;
  logic [NUM_TW_P-1:0]        r_rd_vld;
  logic [rf_addr_width_p-1:0] r_rs0     [NUM_TW_P];
  logic [rf_addr_width_p-1:0] r_rs1     [NUM_TW_P];
  logic [rf_addr_width_p-1:0] r_rd      [NUM_TW_P];
  logic [NUM_REGS_LP-1:0]     r_pend    [NUM_TW_P];
  logic [twid_width_lp-1:0]   r_rr_ptr;

  logic [NUM_TW_P-1:0]        w_elig;
  logic                       w_gnt_vld;
  logic [twid_width_lp-1:0]   w_gnt_idx;
  logic                       w_accept;

  // Eligibility looks only at registered scoreboard state; writebacks take effect next cycle.
  always_comb begin
    w_elig = '0;
    for (int w = 0; w < NUM_TW_P; w++) begin
      w_elig[w] = r_slot_vld[w]
                & ~(flush_vld_i & (flush_twid_i == twid_width_lp'(w)))
                & ~(r_rs0_vld[w] & r_pend[w][r_rs0[w]])
                & ~(r_rs1_vld[w] & r_pend[w][r_rs1[w]])
                & ~(r_rd_vld[w]  & r_pend[w][r_rd[w]])
                & fu_rdy_i[r_fu[w]];
    end
  end

  mrv_rr_arbiter #(.N(NUM_TW_P)) u_rr_arbiter (
    .req     (w_elig),
    .ptr     (r_rr_ptr),
    .gnt_vld (w_gnt_vld),
    .gnt_idx (w_gnt_idx)
  );

  assign issue_vld_o     = w_gnt_vld;
  assign issue_twid_o    = w_gnt_vld ? w_gnt_idx : '0;
  assign issue_fu_type_o = w_gnt_vld ? r_fu[w_gnt_idx] : MRV_FU_ALU;

  assign dec_rdy_o = ~(flush_vld_i & (flush_twid_i == dec_twid_i))
                   & (~r_slot_vld[dec_twid_i] | (w_gnt_vld & (w_gnt_idx == dec_twid_i)));
  assign w_accept  = dec_vld_i & dec_rdy_o;

  // Slot fill on accept; issue or flush empties it, but a same-cycle refill takes priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_slot_vld <= '0;
      r_rs0_vld  <= '0;
      r_rs1_vld  <= '0;
      r_rd_vld   <= '0;
      for (int w = 0; w < NUM_TW_P; w++) begin
        r_fu[w]  <= MRV_FU_ALU;
        r_rs0[w] <= '0;
        r_rs1[w] <= '0;
        r_rd[w]  <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_TW_P; w++) begin
        if (w_accept && (dec_twid_i == twid_width_lp'(w))) begin
          r_slot_vld[w] <= 1'b1;
          r_fu[w]       <= dec_fu_type_i;
          r_rs0_vld[w]  <= dec_rs0_vld_i;
          r_rs1_vld[w]  <= dec_rs1_vld_i;
          r_rd_vld[w]   <= dec_rd_vld_i;
          r_rs0[w]      <= dec_rs0_addr_i;
          r_rs1[w]      <= dec_rs1_addr_i;
          r_rd[w]       <= dec_rd_addr_i;
        end else if ((flush_vld_i && (flush_twid_i == twid_width_lp'(w))) ||
                     (w_gnt_vld && (w_gnt_idx == twid_width_lp'(w)))) begin
          r_slot_vld[w] <= 1'b0;
        end
      end
    end
  end

  // Scoreboard: the issue set is written after the writeback clear so a collision keeps the bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < NUM_TW_P; w++) begin
        r_pend[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_TW_P; w++) begin
        if (wb_vld_i && (wb_twid_i == twid_width_lp'(w))) begin
          r_pend[w][wb_rd_addr_i] <= 1'b0;
        end
        if (w_gnt_vld && (w_gnt_idx == twid_width_lp'(w)) && r_rd_vld[w] &&
            (r_rd[w] != '0)) begin
          r_pend[w][r_rd[w]] <= 1'b1;
        end
      end
    end
  end

  // Round-robin pointer moves just past the winner and holds when nothing issues.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_rr_ptr <= (w_gnt_idx == twid_width_lp'(NUM_TW_P - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

endmodule
